// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state type and bit-timing helper
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    function automatic int cycles_per_bit(input int clk_fre, input int baud_rate);
        return (clk_fre * 1000000) / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART serializer: FSM, shift register, bit timer; parity via UART_OUTPUT_PARITY_EN
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FRE   = 50,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_byte,
    input  logic       tx_byte_valid,
    output logic       tx_byte_ready,
    output logic       tx,
    output logic       busy
);

    localparam int CPB = cycles_per_bit(CLK_FRE, BAUD_RATE);
    localparam int CW  = $clog2(CPB + 1);

    uart_state_t state, state_nxt;
    logic [CW-1:0] cyc_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          parity;
    logic          bit_end;
    logic          load;
    logic          tx_nxt;

    assign bit_end = (cyc_cnt == CW'(CPB - 1));
    assign load    = tx_byte_valid && tx_byte_ready;
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A new byte is only taken from IDLE or on the final cycle of STOP, so frames chain without a gap.
    always_comb begin
        state_nxt     = state;
        tx_nxt        = 1'b1;
        tx_byte_ready = 1'b0;
        case (state)
            IDLE: begin
                tx_byte_ready = 1'b1;
                if (tx_byte_valid) state_nxt = START;
            end
            START: begin
                tx_nxt = 1'b0;
                if (bit_end) state_nxt = DATA;
            end
            DATA: begin
                tx_nxt = shift[0];
                if (bit_end && bit_cnt == 3'd7) begin
`ifdef UART_OUTPUT_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = STOP;
`endif
                end
            end
            PARITY: begin
                tx_nxt = parity;
                if (bit_end) state_nxt = STOP;
            end
            STOP: begin
                tx_byte_ready = bit_end;
                if (bit_end) state_nxt = tx_byte_valid ? START : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The line is registered, so it trails the state by one clock for every bit alike.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx      <= 1'b1;
            cyc_cnt <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            parity  <= 1'b0;
        end else begin
            tx <= tx_nxt;
            if (load) begin
                shift  <= tx_byte;
                parity <= ^tx_byte;
            end else if (state == DATA && bit_end) begin
                shift <= {1'b0, shift[7:1]};
            end
            if (state == IDLE || bit_end) begin
                cyc_cnt <= '0;
            end else begin
                cyc_cnt <= cyc_cnt + CW'(1);
            end
            if (state == DATA && bit_end) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

endmodule

// File: rtl/uart_output.sv
// rtl/uart_output.sv - UART transmit path: byte FIFO feeding uart_tx; parity via UART_OUTPUT_PARITY_EN
module uart_output #(
    parameter int CLK_FRE    = 50,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] uart_byte,
    input  logic       uart_byte_valid,
    output logic       uart_byte_ready,
    output logic       uart_tx,
    output logic       tx_busy
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        full, empty, push, pop;
    logic        ready_en, ser_ready, ser_busy, fifo_valid;

    assign empty           = (wr_ptr == rd_ptr);
    assign full            = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign fifo_valid      = !empty;
    assign uart_byte_ready = ready_en && !full;
    assign push            = uart_byte_valid && uart_byte_ready;
    assign pop             = fifo_valid && ser_ready;
    assign tx_busy         = fifo_valid || ser_busy;

    // ready_en holds acceptance off until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            ready_en <= 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= uart_byte;
    end

    uart_tx #(
        .CLK_FRE   (CLK_FRE),
        .BAUD_RATE (BAUD_RATE)
    ) u_tx (
        .clk           (clk),
        .rst_n         (rst_n),
        .tx_byte       (mem[rd_ptr[AW-1:0]]),
        .tx_byte_valid (fifo_valid),
        .tx_byte_ready (ser_ready),
        .tx            (uart_tx),
        .busy          (ser_busy)
    );

endmodule

// File: tb/tb_uart_output.sv
// tb/tb_uart_output.sv - scoreboard bench for uart_output; honours UART_OUTPUT_PARITY_EN
module tb_uart_output;

    localparam int CPB = 434;
`ifdef UART_OUTPUT_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] uart_byte;
    logic       uart_byte_valid;
    logic       uart_byte_ready;
    logic       uart_tx;
    logic       tx_busy;

    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;
    int   acc_cnt = 0;
    int   frames_done = 0;
    int   last_start = 0;
    bit   in_frame = 1'b0;
    bit   chain = 1'b0;
    bit   have_last = 1'b0;
    logic prev_line = 1'b1;
    logic [7:0] sb [$];

    uart_output #(
        .CLK_FRE    (50),
        .BAUD_RATE  (115200),
        .FIFO_DEPTH (4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .uart_byte       (uart_byte),
        .uart_byte_valid (uart_byte_valid),
        .uart_byte_ready (uart_byte_ready),
        .uart_tx         (uart_tx),
        .tx_busy         (tx_busy)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rst_n && uart_byte_valid && uart_byte_ready) begin
            sb.push_back(uart_byte);
            acc_cnt = acc_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Frame monitor: checks both ends of every bit period against the scoreboard head.
    initial begin : monitor
        logic [7:0]            eb;
        logic [FRAME_BITS-1:0] fbits;
        bit                    aborted;
        forever begin
            @(negedge clk);
            if (rst_n && prev_line === 1'b1 && uart_tx === 1'b0) begin
                in_frame = 1'b1;
                aborted  = 1'b0;
                check("frame_expected", 32'(sb.size() > 0), 32'd1);
                eb = (sb.size() > 0) ? sb[0] : 8'h00;
`ifdef UART_OUTPUT_PARITY_EN
                fbits = {1'b1, ^eb, eb, 1'b0};
`else
                fbits = {1'b1, eb, 1'b0};
`endif
                if (chain && have_last) check("frame_gap", 32'(cyc - last_start), 32'(FRAME_BITS * CPB));
                last_start = cyc;
                have_last  = 1'b1;
                for (int k = 0; k < FRAME_BITS * CPB; k++) begin
                    if (k > 0) @(negedge clk);
                    if (!rst_n) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (k % CPB == 0 || k % CPB == CPB - 1)
                        check($sformatf("byte%0h_bit%0d", eb, k / CPB), 32'(uart_tx), 32'(fbits[k / CPB]));
                end
                if (!aborted) begin
                    if (sb.size() > 0) void'(sb.pop_front());
                    frames_done++;
                end
                in_frame = 1'b0;
            end
            prev_line = uart_tx;
        end
    end

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((sb.size() != 0 || in_frame || tx_busy) && n < 40000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n < 40000), 32'd1);
        @(negedge clk);
    endtask

    task automatic push_byte(input logic [7:0] b, output int n);
        @(negedge clk);
        uart_byte       = b;
        uart_byte_valid = 1'b1;
        @(negedge clk);
        uart_byte_valid = 1'b0;
        n = cyc;
    endtask

    task automatic send_single(input logic [7:0] b);
        int n0;
        int t = 0;
        push_byte(b, n0);
        @(negedge clk);
        check("latency_n1_high", 32'(uart_tx), 32'd1);
        @(negedge clk);
        check("latency_n2_low", 32'(uart_tx), 32'd0);
        while (tx_busy && t < 20000) begin
            @(negedge clk);
            t++;
        end
        check("busy_duration", 32'(cyc - n0), 32'(FRAME_BITS * CPB + 1));
        wait_idle("single_idle");
    endtask

    initial begin : stim
        int n0;
        int t;
        int fb;
        rst_n           = 1'b0;
        uart_byte       = 8'h00;
        uart_byte_valid = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_tx", 32'(uart_tx), 32'd1);
        check("rst_ready", 32'(uart_byte_ready), 32'd0);
        check("rst_busy", 32'(tx_busy), 32'd0);
        rst_n = 1'b1;
        #1 check("ready_before_edge", 32'(uart_byte_ready), 32'd0);
        @(negedge clk);
        check("ready_after_edge", 32'(uart_byte_ready), 32'd1);

        send_single(8'h55);

        chain     = 1'b1;
        have_last = 1'b0;
        fb        = frames_done;
        @(negedge clk);
        uart_byte = 8'h00; uart_byte_valid = 1'b1;
        @(negedge clk);
        uart_byte = 8'hFF;
        @(negedge clk);
        uart_byte = 8'hA5;
        @(negedge clk);
        uart_byte_valid = 1'b0;
        wait_idle("burst3_idle");
        check("burst3_frames", 32'(frames_done - fb), 32'd3);

        have_last = 1'b0;
        acc_cnt   = 0;
        fb        = frames_done;
        n0        = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            uart_byte       = 8'h10 + 8'(i);
            uart_byte_valid = 1'b1;
            if (i == 1) n0 = cyc;
        end
        @(negedge clk);
        uart_byte_valid = 1'b0;
        check("hold_accepted", 32'(acc_cnt), 32'd5);
        check("hold_ready_low", 32'(uart_byte_ready), 32'd0);
        t = 0;
        while (!uart_byte_ready && t < 20000) begin
            @(negedge clk);
            t++;
        end
        check("hold_ready_rise", 32'(cyc - n0), 32'(FRAME_BITS * CPB + 1));
        wait_idle("hold_idle");
        check("hold_frames", 32'(frames_done - fb), 32'd5);
        chain = 1'b0;

        fb = frames_done;
        push_byte(8'h3C, n0);
        repeat (1070) @(negedge clk);
        check("mid_data_line", 32'(uart_tx), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_tx", 32'(uart_tx), 32'd1);
        check("async_rst_busy", 32'(tx_busy), 32'd0);
        check("async_rst_ready", 32'(uart_byte_ready), 32'd0);
        sb.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1 check("rerelease_ready_low", 32'(uart_byte_ready), 32'd0);
        @(negedge clk);
        check("rerelease_ready_high", 32'(uart_byte_ready), 32'd1);
        send_single(8'h81);
        check("after_rst_frames", 32'(frames_done - fb), 32'd1);

`ifdef UART_OUTPUT_PARITY_EN
        send_single(8'h07);
        send_single(8'h03);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/uart_output.md
UART_OUTPUT -- requirements
Module: uart_output

Interface
REQ-001 Parameter CLK_FRE, default 50, SHALL be the system clock frequency in MHz.
REQ-002 Parameter BAUD_RATE, default 115200, SHALL be the serial bit rate in bits/s.
REQ-003 Parameter FIFO_DEPTH, default 4, SHALL be the transmit FIFO entry count; power of two, >=2.
REQ-004 clk  input  1  SHALL be the single system clock; all logic on its rising edge.
REQ-005 rst_n  input  1  SHALL be the reset; asynchronous, active-low.
REQ-006 uart_byte  input  8  SHALL be the byte to transmit.
REQ-007 uart_byte_valid  input  1  SHALL mean uart_byte holds a byte offered for transmission.
REQ-008 uart_byte_ready  output  1  SHALL mean the block accepts a byte this cycle.
REQ-009 uart_tx  output  1  SHALL be the serial line; idle high.
REQ-010 tx_busy  output  1  SHALL be high while the FIFO is non-empty or a frame is in progress.

Function
REQ-011 CYCLES_PER_BIT SHALL equal CLK_FRE*1000000/BAUD_RATE, truncated (434 at defaults); each bit held exactly CYCLES_PER_BIT clocks.
REQ-012 A byte SHALL be accepted on a rising edge where uart_byte_valid && uart_byte_ready; uart_byte_ready = FIFO not full, independent of uart_byte_valid.
REQ-013 Frame SHALL be: start bit 0, 8 data bits LSB first, optional parity (REQ-024), one stop bit 1.
REQ-014 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-015 IDLE: uart_tx=1; when FIFO non-empty, pop head into shift register, go to START next cycle.
REQ-016 START -> DATA after one bit period; DATA -> PARITY (macro defined) or STOP after the 8th bit period; PARITY -> STOP after one bit period.
REQ-017 STOP: after its bit period, go to START with a pop if FIFO non-empty, else IDLE; back-to-back frames SHALL have no idle gap.
REQ-018 Latency: byte accepted at edge N into an empty FIFO with FSM in IDLE SHALL drive uart_tx low from edge N+2.
REQ-019 Push and pop in the same cycle SHALL both take effect; occupancy unchanged.
REQ-020 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL use an extra pointer bit, never a lost entry.
REQ-021 Valid held high while uart_byte_ready is low SHALL NOT write; data SHALL be neither lost nor duplicated.

Reset
REQ-022 While rst_n=0: uart_tx=1, uart_byte_ready=0, tx_busy=0, FSM=IDLE, FIFO empty, bit/cycle counters 0; uart_tx SHALL go high asynchronously even mid-frame.
REQ-023 uart_byte_ready SHALL rise on the first clock edge after rst_n deasserts; a partially sent frame SHALL be discarded, not resumed.

Configuration
REQ-024 Macro UART_OUTPUT_PARITY_EN defined: PARITY state SHALL send even parity (XOR of the 8 data bits), frame = 11 bit periods; undefined: PARITY state SHALL be unreachable, frame = 10 bit periods.

Structure
REQ-025 Package uart_pkg SHALL hold the state enum type and a cycles-per-bit constant function shared with the receive path.
REQ-026 The serializer (FSM, shift register, bit timer) SHALL be sub-module uart_tx with the same CLK_FRE/BAUD_RATE parameters and a valid/ready byte port; uart_output SHALL contain the FIFO and instantiate uart_tx.

Verification (CLK_FRE=50, BAUD_RATE=115200, 434 clk/bit)
REQ-027 Push 0x55 once -> uart_tx low at edge N+2; line sequence 0,1,0,1,0,1,0,1,0,1 each 434 clks; tx_busy falls after 4340 clks; macro off.
REQ-028 Push 0x00,0xFF,0xA5 on consecutive cycles -> three frames contiguous, no idle gap, 13020 clks total, bytes bit-exact in order.
REQ-029 Hold valid for 8 cycles with depth 4 -> exactly 5 bytes accepted (1 popped + 4 queued); uart_byte_ready low until first STOP-to-START pop; all 5 transmitted in order.
REQ-030 Assert rst_n=0 mid-DATA of 0x3C -> uart_tx=1 immediately, tx_busy=0; after release, push 0x81 -> one clean frame of 0x81 only.
REQ-031 With UART_OUTPUT_PARITY_EN, push 0x07 -> parity bit 1, frame 4774 clks; push 0x03 -> parity bit 0.
